lc3_execute_stage: RTL and testbench



---
 rtl/lc3_exec_pkg.sv | 55 +++++
 rtl/lc3_exec_alu.sv | 71 +++++++
 rtl/lc3_execute_stage.sv | 113 +++++++++++
 tb/tb_lc3_execute_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_exec_pkg.sv
// Shared types and constants for the LC3 execute stage: control-word layout,
// ALU/address-adder selects, opcode values and the registered output payload.
package lc3_exec_pkg;

  localparam int unsigned LC3_DW  = 16;
  localparam int unsigned ECTL_W  = 6;
  localparam int unsigned WCTL_W  = 2;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned NZP_W   = 3;
  localparam int unsigned OPC_W   = 4;

  // Bit positions inside E_Control.
  localparam int unsigned ECTL_ALU_OP_MSB = 5;
  localparam int unsigned ECTL_ALU_OP_LSB = 4;
  localparam int unsigned ECTL_PCSEL1_MSB = 3;
  localparam int unsigned ECTL_PCSEL1_LSB = 2;
  localparam int unsigned ECTL_PCSEL2_BIT = 1;
  localparam int unsigned ECTL_OP2SEL_BIT = 0;

  localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_HOLD = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PC1_OFF11 = 2'b00,
    PC1_OFF9  = 2'b01,
    PC1_OFF6  = 2'b10,
    PC1_ZERO  = 2'b11
  } pcsel1_e;

  typedef struct packed {
    alu_op_e alu_op;
    pcsel1_e pcsel1;
    logic    pcsel2;
    logic    op2sel;
  } ectl_t;

  typedef struct packed {
    logic [WCTL_W-1:0] w_control;
    logic              mem_control;
    logic [REG_W-1:0]  dr;
    logic [NZP_W-1:0]  nzp;
    logic [LC3_DW-1:0] aluout;
    logic [LC3_DW-1:0] pcout;
    logic [LC3_DW-1:0] m_data;
    logic [LC3_DW-1:0] ir;
  } exec_out_t;

endpackage

// File: rtl/lc3_exec_alu.sv
// Combinational datapath of the execute stage: operand forwarding mux,
// ALU and the PC-relative / base-register address adder.
module lc3_exec_alu
  import lc3_exec_pkg::*;
#(
  parameter int unsigned DW = LC3_DW
) (
  input  ectl_t         ectl_i,
  input  logic [10:0]   ir_i,
  input  logic [DW-1:0] npc_i,
  input  logic [DW-1:0] vsr1_i,
  input  logic [DW-1:0] vsr2_i,
  input  logic [DW-1:0] aluout_q_i,
  input  logic [DW-1:0] mem_bypass_val_i,
  input  logic          bypass_alu_1_i,
  input  logic          bypass_alu_2_i,
  input  logic          bypass_mem_1_i,
  input  logic          bypass_mem_2_i,
  output logic [DW-1:0] alu_res_c_o,
  output logic [DW-1:0] pcout_c_o,
  output logic [DW-1:0] m_data_c_o
);

  logic [DW-1:0] v1;
  logic [DW-1:0] v2;
  logic [DW-1:0] op2;
  logic [DW-1:0] a1;
  logic [DW-1:0] a2;

  // ALU forwarding beats memory forwarding: it carries the younger result.
  always_comb begin
    v1 = vsr1_i;
    if (bypass_alu_1_i) begin
      v1 = aluout_q_i;
    end else if (bypass_mem_1_i) begin
      v1 = mem_bypass_val_i;
    end
    v2 = vsr2_i;
    if (bypass_alu_2_i) begin
      v2 = aluout_q_i;
    end else if (bypass_mem_2_i) begin
      v2 = mem_bypass_val_i;
    end
  end

  always_comb begin
    op2 = ectl_i.op2sel ? v2 : {{(DW-5){ir_i[4]}}, ir_i[4:0]};
    alu_res_c_o = aluout_q_i;
    case (ectl_i.alu_op)
      ALU_ADD: alu_res_c_o = v1 + op2;
      ALU_AND: alu_res_c_o = v1 & op2;
      ALU_NOT: alu_res_c_o = ~v1;
      default: alu_res_c_o = aluout_q_i;
    endcase
  end

  always_comb begin
    a1 = '0;
    case (ectl_i.pcsel1)
      PC1_OFF11: a1 = {{(DW-11){ir_i[10]}}, ir_i[10:0]};
      PC1_OFF9:  a1 = {{(DW-9){ir_i[8]}},   ir_i[8:0]};
      PC1_OFF6:  a1 = {{(DW-6){ir_i[5]}},   ir_i[5:0]};
      default:   a1 = '0;
    endcase
    a2 = ectl_i.pcsel2 ? npc_i : v1;
    pcout_c_o = a1 + a2;
  end

  assign m_data_c_o = v2;

endmodule

// File: rtl/lc3_execute_stage.sv
// LC3 execute stage: registers ALU result, address, store data, NZP mask and
// pass-through controls onto the execute_out bus, one cycle after decode.
module lc3_execute_stage
  import lc3_exec_pkg::*;
#(
  parameter int unsigned      DW      = LC3_DW,
  parameter logic [NZP_W-1:0] NZP_JMP = 3'b111
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic [ECTL_W-1:0] E_Control,
  input  logic [WCTL_W-1:0] W_Control_in,
  input  logic              Mem_Control_in,
  input  logic [DW-1:0]     IR,
  input  logic [DW-1:0]     npc_in,
  input  logic [DW-1:0]     VSR1,
  input  logic [DW-1:0]     VSR2,
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
  input  logic              bypass_mem_1,
  input  logic              bypass_mem_2,
  input  logic [DW-1:0]     Mem_Bypass_Val,
  output logic              enable_execute_out,
  output logic [WCTL_W-1:0] W_Control_out,
  output logic              Mem_Control_out,
  output logic [REG_W-1:0]  sr1,
  output logic [REG_W-1:0]  sr2,
  output logic [REG_W-1:0]  dr,
  output logic [NZP_W-1:0]  NZP,
  output logic [DW-1:0]     aluout,
  output logic [DW-1:0]     pcout,
  output logic [DW-1:0]     M_Data,
  output logic [DW-1:0]     IR_Exec
);

  ectl_t          ectl;
  exec_out_t      ex_q;
  exec_out_t      ex_d;
  logic           en_q;
  logic [DW-1:0]  alu_res_c;
  logic [DW-1:0]  pcout_c;
  logic [DW-1:0]  m_data_c;
  logic [NZP_W-1:0] nzp_c;

  assign ectl = ectl_t'(E_Control);

  lc3_exec_alu #(
    .DW (DW)
  ) u_alu (
    .ectl_i           (ectl),
    .ir_i             (IR[10:0]),
    .npc_i            (npc_in),
    .vsr1_i           (VSR1),
    .vsr2_i           (VSR2),
    .aluout_q_i       (ex_q.aluout),
    .mem_bypass_val_i (Mem_Bypass_Val),
    .bypass_alu_1_i   (bypass_alu_1),
    .bypass_alu_2_i   (bypass_alu_2),
    .bypass_mem_1_i   (bypass_mem_1),
    .bypass_mem_2_i   (bypass_mem_2),
    .alu_res_c_o      (alu_res_c),
    .pcout_c_o        (pcout_c),
    .m_data_c_o       (m_data_c)
  );

  // Branch condition mask: BR carries its own nzp bits, JMP/RET always taken.
  always_comb begin
    nzp_c = '0;
    case (IR[15:12])
      OP_BR:   nzp_c = IR[11:9];
      OP_JMP:  nzp_c = NZP_JMP;
      default: nzp_c = '0;
    endcase
  end

  always_comb begin
    ex_d = ex_q;
    if (enable_execute) begin
      ex_d.w_control   = W_Control_in;
      ex_d.mem_control = Mem_Control_in;
      ex_d.dr          = IR[11:9];
      ex_d.nzp         = nzp_c;
      ex_d.aluout      = alu_res_c;
      ex_d.pcout       = pcout_c;
      ex_d.m_data      = m_data_c;
      ex_d.ir          = IR;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
      en_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      en_q <= enable_execute;
    end
  end

  assign enable_execute_out = en_q;
  assign W_Control_out      = ex_q.w_control;
  assign Mem_Control_out    = ex_q.mem_control;
  assign dr                 = ex_q.dr;
  assign NZP                = ex_q.nzp;
  assign aluout             = ex_q.aluout;
  assign pcout              = ex_q.pcout;
  assign M_Data             = ex_q.m_data;
  assign IR_Exec            = ex_q.ir;
  assign sr1                = IR[8:6];
  assign sr2                = IR[2:0];

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Directed, table-driven bench for lc3_execute_stage with hand-computed
// expectations plus reset, stall and reset-release sequences.
module tb_lc3_execute_stage;

  logic        clock;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [15:0] Mem_Bypass_Val;
  logic        enable_execute_out;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [2:0]  dr;
  logic [2:0]  NZP;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] M_Data;
  logic [15:0] IR_Exec;

  int total = 0;
  int bad   = 0;

  lc3_execute_stage dut (
    .clock              (clock),
    .reset              (reset),
    .enable_execute     (enable_execute),
    .E_Control          (E_Control),
    .W_Control_in       (W_Control_in),
    .Mem_Control_in     (Mem_Control_in),
    .IR                 (IR),
    .npc_in             (npc_in),
    .VSR1               (VSR1),
    .VSR2               (VSR2),
    .bypass_alu_1       (bypass_alu_1),
    .bypass_alu_2       (bypass_alu_2),
    .bypass_mem_1       (bypass_mem_1),
    .bypass_mem_2       (bypass_mem_2),
    .Mem_Bypass_Val     (Mem_Bypass_Val),
    .enable_execute_out (enable_execute_out),
    .W_Control_out      (W_Control_out),
    .Mem_Control_out    (Mem_Control_out),
    .sr1                (sr1),
    .sr2                (sr2),
    .dr                 (dr),
    .NZP                (NZP),
    .aluout             (aluout),
    .pcout              (pcout),
    .M_Data             (M_Data),
    .IR_Exec            (IR_Exec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic [15:0] mbv;
    logic [5:0]  ectl;
    logic [1:0]  wctl;
    logic        mctl;
    logic [3:0]  byp;     // {alu_1, alu_2, mem_1, mem_2}
    logic [15:0] e_alu;
    logic [15:0] e_pc;
    logic [15:0] e_md;
    logic [2:0]  e_nzp;
    logic [2:0]  e_dr;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic en);
    IR             = v.ir;
    npc_in         = v.npc;
    VSR1           = v.vsr1;
    VSR2           = v.vsr2;
    Mem_Bypass_Val = v.mbv;
    E_Control      = v.ectl;
    W_Control_in   = v.wctl;
    Mem_Control_in = v.mctl;
    bypass_alu_1   = v.byp[3];
    bypass_alu_2   = v.byp[2];
    bypass_mem_1   = v.byp[1];
    bypass_mem_2   = v.byp[0];
    enable_execute = en;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_regs(input string tag, input vec_t v, input logic en_exp);
    chk({tag, " aluout"},  aluout, v.e_alu);
    chk({tag, " pcout"},   pcout,  v.e_pc);
    chk({tag, " M_Data"},  M_Data, v.e_md);
    chk({tag, " NZP"},     16'(NZP), 16'(v.e_nzp));
    chk({tag, " dr"},      16'(dr), 16'(v.e_dr));
    chk({tag, " IR_Exec"}, IR_Exec, v.ir);
    chk({tag, " W_Ctl"},   16'(W_Control_out), 16'(v.wctl));
    chk({tag, " Mem_Ctl"}, 16'(Mem_Control_out), 16'(v.mctl));
    chk({tag, " en_out"},  16'(enable_execute_out), 16'(en_exp));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " aluout"},  aluout, 16'h0000);
    chk({tag, " pcout"},   pcout, 16'h0000);
    chk({tag, " M_Data"},  M_Data, 16'h0000);
    chk({tag, " IR_Exec"}, IR_Exec, 16'h0000);
    chk({tag, " NZP"},     16'(NZP), 16'h0000);
    chk({tag, " dr"},      16'(dr), 16'h0000);
    chk({tag, " W_Ctl"},   16'(W_Control_out), 16'h0000);
    chk({tag, " Mem_Ctl"}, 16'(Mem_Control_out), 16'h0000);
    chk({tag, " en_out"},  16'(enable_execute_out), 16'h0000);
  endtask

  initial begin
    vec_t rv;
    vec_t held;

    //            ir       npc      vsr1     vsr2     mbv      ectl       w  m  byp      alu      pc       md       nzp     dr
    vecs[0]  = '{16'h1262, 16'h0000, 16'h0005, 16'h1234, 16'h0000, 6'b000000, 2'd1, 1'b0, 4'b0000, 16'h0007, 16'h0267, 16'h1234, 3'b000, 3'd1};
    vecs[1]  = '{16'h1042, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 6'b000001, 2'd2, 1'b1, 4'b0000, 16'h0001, 16'h0041, 16'h0002, 3'b000, 3'd0};
    vecs[2]  = '{16'h5042, 16'h0000, 16'hF0F0, 16'h0FF0, 16'h0000, 6'b010001, 2'd3, 1'b0, 4'b0000, 16'h00F0, 16'hF132, 16'h0FF0, 3'b000, 3'd0};
    vecs[3]  = '{16'h907F, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 6'b100000, 2'd0, 1'b1, 4'b0000, 16'hEDCB, 16'h12B3, 16'h0000, 3'b000, 3'd0};
    vecs[4]  = '{16'h0403, 16'h3001, 16'h0000, 16'h5555, 16'h0000, 6'b110110, 2'd0, 1'b0, 4'b0000, 16'hEDCB, 16'h3004, 16'h5555, 3'b010, 3'd2};
    vecs[5]  = '{16'h0FFE, 16'h3001, 16'h0000, 16'h0000, 16'h0000, 6'b110110, 2'd0, 1'b0, 4'b0000, 16'hEDCB, 16'h2FFF, 16'h0000, 3'b111, 3'd7};
    vecs[6]  = '{16'hC1C0, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 6'b111100, 2'd0, 1'b0, 4'b0000, 16'hEDCB, 16'h4000, 16'h0000, 3'b111, 3'd0};
    vecs[7]  = '{16'h6A7F, 16'h0000, 16'h0100, 16'hABCD, 16'h0000, 6'b001000, 2'd1, 1'b1, 4'b0000, 16'h00FF, 16'h00FF, 16'hABCD, 3'b000, 3'd5};
    vecs[8]  = '{16'h1020, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 6'b000000, 2'd1, 1'b0, 4'b0000, 16'h0010, 16'h0030, 16'h0000, 3'b000, 3'd0};
    vecs[9]  = '{16'h1020, 16'h0000, 16'h0999, 16'h0000, 16'h0020, 6'b000000, 2'd1, 1'b0, 4'b1010, 16'h0010, 16'h0030, 16'h0000, 3'b000, 3'd0};
    vecs[10] = '{16'h1020, 16'h0000, 16'h0999, 16'h0000, 16'h0020, 6'b000000, 2'd1, 1'b0, 4'b0010, 16'h0020, 16'h0040, 16'h0000, 3'b000, 3'd0};
    vecs[11] = '{16'h1001, 16'h0000, 16'h0100, 16'h0777, 16'h0020, 6'b000001, 2'd2, 1'b1, 4'b0101, 16'h0120, 16'h0101, 16'h0020, 3'b000, 3'd0};
    vecs[12] = '{16'h1001, 16'h0000, 16'h0001, 16'h0777, 16'h0300, 6'b000001, 2'd2, 1'b1, 4'b0001, 16'h0301, 16'h0002, 16'h0300, 3'b000, 3'd0};

    // Reset held with enable high and random inputs: everything stays zero.
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rv = vecs[0];
      rv.ir   = 16'($urandom);
      rv.npc  = 16'($urandom);
      rv.vsr1 = 16'($urandom);
      rv.vsr2 = 16'($urandom);
      rv.mbv  = 16'($urandom);
      rv.ectl = 6'($urandom);
      rv.wctl = 2'($urandom);
      rv.mctl = 1'($urandom);
      rv.byp  = 4'($urandom);
      drive(rv, 1'b1);
      tick();
      chk_zero($sformatf("rst%0d", c));
      chk($sformatf("rst%0d sr1", c), 16'(sr1), 16'(rv.ir[8:6]));
      chk($sformatf("rst%0d sr2", c), 16'(sr2), 16'(rv.ir[2:0]));
    end
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      #1;
      chk($sformatf("v%0d sr1", i), 16'(sr1), 16'(vecs[i].ir[8:6]));
      chk($sformatf("v%0d sr2", i), 16'(sr2), 16'(vecs[i].ir[2:0]));
      tick();
      chk_regs($sformatf("v%0d", i), vecs[i], 1'b1);
    end

    // Stall: inputs keep changing but the payload registers hold.
    held = vecs[NV-1];
    for (int s = 0; s < 3; s++) begin
      drive(vecs[s + 2], 1'b0);
      tick();
      chk_regs($sformatf("stall%0d", s), held, 1'b0);
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    drive(vecs[3], 1'b1);
    tick();
    chk_regs("resume", vecs[3], 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async");
    tick();
    reset = 1'b1;

    // After release, ALU forwarding sees the cleared aluout.
    rv = vecs[0];
    rv.vsr1 = 16'h0999;
    rv.byp  = 4'b1000;
    drive(rv, 1'b1);
    tick();
    rv.e_alu = 16'h0002;
    rv.e_pc  = 16'h0262;
    chk_regs("post_rst", rv, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
